// File: rtl/demux12_if.sv
// Stream bus for demux12: one select-tagged input stream and two valid/ready output channels.
// The per-channel word counters cnt0/cnt1 exist only when DEMUX12_CNT_EN is defined.
interface demux12_if #(
    parameter int Size = 8
);
    logic            in_valid;
    logic            in_ready;
    logic            s;
    logic [Size-1:0] d;
    logic            v0;
    logic            r0;
    logic [Size-1:0] a0;
    logic            v1;
    logic            r1;
    logic [Size-1:0] a1;
`ifdef DEMUX12_CNT_EN
    logic [15:0]     cnt0;
    logic [15:0]     cnt1;
`endif

    // slave is the demultiplexer side, master drives input and consumes outputs
    modport slave (
        input  in_valid, s, d, r0, r1,
`ifdef DEMUX12_CNT_EN
        output cnt0, cnt1,
`endif
        output in_ready, v0, a0, v1, a1
    );

    modport master (
        output in_valid, s, d, r0, r1,
`ifdef DEMUX12_CNT_EN
        input  cnt0, cnt1,
`endif
        input  in_ready, v0, a0, v1, a1
    );
endinterface

// File: rtl/demux12.sv
// Registered 1-to-2 stream demultiplexer: each accepted word lands in a 2-entry FIFO per channel.
// Defining DEMUX12_CNT_EN adds 16-bit wrapping accepted-word counters per channel.
module demux12 #(
    parameter int Size = 8
) (
    input logic      clk,
    input logic      rst_n,
    demux12_if.slave bus
);
    logic [1:0]      full;
    logic [1:0]      valid;
    logic [1:0]      push;
    logic [1:0]      pop;
    logic [1:0]      rdy;
    logic [Size-1:0] head [2];
`ifdef DEMUX12_CNT_EN
    logic [15:0]     cnt_w [2];
`endif

    assign rdy = {bus.r1, bus.r0};
    // Ready looks only at the selected channel's registered occupancy, never at r0/r1
    assign bus.in_ready = ~full[bus.s];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ch
            logic [Size-1:0] mem_q [2];
            logic            wptr_q;
            logic            rptr_q;
            logic [1:0]      occ_q;
            logic [1:0]      occ_d;

            assign push[gi]  = bus.in_valid & bus.in_ready & (bus.s == 1'(gi));
            assign pop[gi]   = valid[gi] & rdy[gi];
            assign valid[gi] = (occ_q != 2'd0);
            assign full[gi]  = (occ_q == 2'd2);
            assign head[gi]  = mem_q[rptr_q];

            always_comb begin
                occ_d = occ_q;
                if (push[gi] && !pop[gi]) begin
                    occ_d = occ_q + 2'd1;
                end else if (pop[gi] && !push[gi]) begin
                    occ_d = occ_q - 2'd1;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    mem_q[0] <= '0;
                    mem_q[1] <= '0;
                    wptr_q   <= 1'b0;
                    rptr_q   <= 1'b0;
                    occ_q    <= 2'd0;
                end else begin
                    if (push[gi]) begin
                        mem_q[wptr_q] <= bus.d;
                        wptr_q        <= ~wptr_q;
                    end
                    if (pop[gi]) begin
                        rptr_q <= ~rptr_q;
                    end
                    occ_q <= occ_d;
                end
            end

`ifdef DEMUX12_CNT_EN
            logic [15:0] cnt_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_q <= 16'h0000;
                end else if (push[gi]) begin
                    cnt_q <= cnt_q + 16'h0001;
                end
            end

            assign cnt_w[gi] = cnt_q;
`endif
        end
    endgenerate

    assign bus.v0 = valid[0];
    assign bus.a0 = head[0];
    assign bus.v1 = valid[1];
    assign bus.a1 = head[1];
`ifdef DEMUX12_CNT_EN
    assign bus.cnt0 = cnt_w[0];
    assign bus.cnt1 = cnt_w[1];
`endif
endmodule

// File: tb/tb_demux12.sv
// Directed plus random bench for demux12 with a per-channel scoreboard queue.
// Counter checks are compiled in only when DEMUX12_CNT_EN is defined.
module tb_demux12;
    logic clk;
    logic rst_n;

    demux12_if #(.Size(8)) bus ();

    demux12 #(.Size(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  q0 [$];
    logic [7:0]  q1 [$];
    logic [15:0] m_cnt0;
    logic [15:0] m_cnt1;
    int          vecs;
    int          errs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check against the model, then advance it at the edge
    task automatic step(input logic iv, input logic is, input logic [7:0] id,
                        input logic ir0, input logic ir1);
        logic model_rdy;
        logic acc;
        @(negedge clk);
        bus.in_valid = iv;
        bus.s        = is;
        bus.d        = id;
        bus.r0       = ir0;
        bus.r1       = ir1;
        #1;
        model_rdy = is ? (q1.size() < 2) : (q0.size() < 2);
        acc       = iv & model_rdy;
        chk("in_ready", 32'(bus.in_ready), 32'(model_rdy));
        chk("v0", 32'(bus.v0), 32'(q0.size() != 0));
        chk("v1", 32'(bus.v1), 32'(q1.size() != 0));
        if (q0.size() != 0) chk("a0", 32'(bus.a0), 32'(q0[0]));
        if (q1.size() != 0) chk("a1", 32'(bus.a1), 32'(q1[0]));
`ifdef DEMUX12_CNT_EN
        chk("cnt0", 32'(bus.cnt0), 32'(m_cnt0));
        chk("cnt1", 32'(bus.cnt1), 32'(m_cnt1));
`endif
        if (q0.size() != 0 && ir0) void'(q0.pop_front());
        if (q1.size() != 0 && ir1) void'(q1.pop_front());
        if (acc) begin
            if (is) begin
                q1.push_back(id);
                m_cnt1 = m_cnt1 + 16'd1;
            end else begin
                q0.push_back(id);
                m_cnt0 = m_cnt0 + 16'd1;
            end
        end
        @(posedge clk);
    endtask

    // Reset for one edge with a push and pops offered; none of them may take effect
    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.s        = 1'b0;
        bus.d        = 8'hEE;
        bus.r0       = 1'b1;
        bus.r1       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        m_cnt0 = 16'd0;
        m_cnt1 = 16'd0;
        chk("rst_v0", 32'(bus.v0), 32'd0);
        chk("rst_v1", 32'(bus.v1), 32'd0);
        chk("rst_a0", 32'(bus.a0), 32'd0);
        chk("rst_a1", 32'(bus.a1), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef DEMUX12_CNT_EN
        chk("rst_cnt0", 32'(bus.cnt0), 32'd0);
        chk("rst_cnt1", 32'(bus.cnt1), 32'd0);
`endif
    endtask

    initial begin
        vecs         = 0;
        errs         = 0;
        m_cnt0       = 16'd0;
        m_cnt1       = 16'd0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.s        = 1'b0;
        bus.d        = 8'h00;
        bus.r0       = 1'b0;
        bus.r1       = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // single word on channel 0, then drain
        step(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        // occupancy 0 with ready high: nothing happens
        step(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);

        // fill channel 1 under back-pressure, third word refused
        step(1'b1, 1'b1, 8'h11, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h22, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h44, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
        // channel 1 full, channel 0 still accepts
        step(1'b1, 1'b1, 8'h66, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h33, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // continuous push+pop at occupancy 1
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h80 + i), 1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        // random traffic
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // both FIFOs full, then reset
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b1, 1'b0, 8'hC0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'hC1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'hD0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'hD1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'hC2, 1'b0, 1'b0);
        do_reset();
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

`ifdef DEMUX12_CNT_EN
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(i), 1'b1, 1'b1);
        for (int i = 0; i < 65537; i++) step(1'b1, 1'b1, 8'(i), 1'b1, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("cnt0_final", 32'(bus.cnt0), 32'd3);
        chk("cnt1_wrapped", 32'(bus.cnt1), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
